// File: rtl/easyaxi_rd_mst_pkg.sv
// Shared widths, protocol constants and FSM encoding for the easy_axi read initiator.
// Every easyaxi_rd_* file imports this package.
package easyaxi_rd_mst_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    // Beat k of every burst carries base+k, wrapped to the data width.
    function automatic logic [AXI_DATA_W-1:0] exp_rdata(
        input logic [AXI_DATA_W-1:0] base,
        input logic [AXI_LEN_W-1:0]  beat
    );
        return base + AXI_DATA_W'(beat);
    endfunction

endpackage

// File: rtl/easyaxi_rd_chk.sv
// R-beat checker: flags a beat whose data, response or last flag is wrong,
// and keeps a saturating count of flagged beats.
module easyaxi_rd_chk
    import easyaxi_rd_mst_pkg::*;
#(
    parameter int                    REQ_LEN   = 3,
    parameter logic [AXI_DATA_W-1:0] DATA_BASE = '0,
    parameter int                    ERR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  beat,
    input  logic [AXI_LEN_W-1:0]  beat_cnt,
    input  logic [AXI_DATA_W-1:0] rdata,
    input  logic [AXI_RESP_W-1:0] rresp,
    input  logic                  rlast,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam logic [AXI_LEN_W-1:0] LEN_C = AXI_LEN_W'(REQ_LEN);

    logic fault;

    // NOTE: fault gets a default before any condition so always_comb never infers a latch.
    always_comb begin
        fault = 1'b0;
        if (rdata != exp_rdata(DATA_BASE, beat_cnt)) fault = 1'b1;
        if (rresp != RESP_OKAY)                     fault = 1'b1;
        if (rlast != (beat_cnt == LEN_C))           fault = 1'b1;
    end

    // Several faults on one beat still count once; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (beat && fault && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: rtl/easyaxi_rd_mst.sv
// easy_axi read initiator: issues REQ_NUM single-outstanding INCR bursts with
// rotating IDs, checks every returned beat, then reports done and an error count.
module easyaxi_rd_mst
    import easyaxi_rd_mst_pkg::*;
#(
    parameter int                    REQ_NUM   = 4,
    parameter logic [AXI_ADDR_W-1:0] REQ_ADDR  = '0,
    parameter int                    REQ_LEN   = 3,
    parameter logic [AXI_SIZE_W-1:0] REQ_SIZE  = 3'b010,
    parameter logic [AXI_DATA_W-1:0] DATA_BASE = '0,
    parameter int                    ERR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   axi_mst_arvalid,
    input  logic                   axi_mst_arready,
    output logic [AXI_ID_W-1:0]    axi_mst_arid,
    output logic [AXI_ADDR_W-1:0]  axi_mst_araddr,
    output logic [AXI_LEN_W-1:0]   axi_mst_arlen,
    output logic [AXI_SIZE_W-1:0]  axi_mst_arsize,
    output logic [AXI_BURST_W-1:0] axi_mst_arburst,
    input  logic                   axi_mst_rvalid,
    output logic                   axi_mst_rready,
    input  logic [AXI_DATA_W-1:0]  axi_mst_rdata,
    input  logic [AXI_RESP_W-1:0]  axi_mst_rresp,
    input  logic                   axi_mst_rlast,
    output logic                   busy,
    output logic                   done,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int                   REQ_CNT_W = $clog2(REQ_NUM + 1);
    localparam logic [REQ_CNT_W-1:0] REQ_NUM_C = REQ_CNT_W'(REQ_NUM);
    localparam logic [AXI_LEN_W-1:0] LEN_C     = AXI_LEN_W'(REQ_LEN);

    rd_state_e              state;
    logic [REQ_CNT_W-1:0]   req_cnt;
    logic [REQ_CNT_W-1:0]   req_nxt;
    logic [AXI_LEN_W-1:0]   beat_cnt;
    logic                   beat;
    logic                   burst_end;
    logic                   session_start;

    // rready is only ever high in R, so this handshake implies state == R.
    assign beat          = axi_mst_rvalid && axi_mst_rready;
    assign burst_end     = axi_mst_rlast || (beat_cnt == LEN_C);
    assign req_nxt       = req_cnt + REQ_CNT_W'(1);
    assign session_start = (state == ST_IDLE) && enable;

    // The AR payload is constant apart from the ID, which only moves between bursts.
    assign axi_mst_arid    = AXI_ID_W'(req_cnt);
    assign axi_mst_araddr  = REQ_ADDR;
    assign axi_mst_arlen   = LEN_C;
    assign axi_mst_arsize  = REQ_SIZE;
    assign axi_mst_arburst = BURST_INCR;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            axi_mst_arvalid <= 1'b0;
            axi_mst_rready  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            req_cnt         <= '0;
            beat_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state           <= ST_AR;
                        axi_mst_arvalid <= 1'b1;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        req_cnt         <= '0;
                    end
                end
                // enable is ignored here: a raised arvalid may not be withdrawn.
                ST_AR: begin
                    if (axi_mst_arready) begin
                        state           <= ST_R;
                        axi_mst_arvalid <= 1'b0;
                        axi_mst_rready  <= 1'b1;
                        beat_cnt        <= '0;
                    end
                end
                ST_R: begin
                    if (beat) begin
                        if (burst_end) begin
                            beat_cnt       <= '0;
                            req_cnt        <= req_nxt;
                            axi_mst_rready <= 1'b0;
                            if (req_nxt == REQ_NUM_C) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (enable) begin
                                state           <= ST_AR;
                                axi_mst_arvalid <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + AXI_LEN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    easyaxi_rd_chk #(
        .REQ_LEN   (REQ_LEN),
        .DATA_BASE (DATA_BASE),
        .ERR_W     (ERR_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .clr      (session_start),
        .beat     (beat),
        .beat_cnt (beat_cnt),
        .rdata    (axi_mst_rdata),
        .rresp    (axi_mst_rresp),
        .rlast    (axi_mst_rlast),
        .err_cnt  (err_cnt)
    );

endmodule
